stage5_pack: RTL and testbench

STAGE5_PACK -- requirements
Module: stage5_pack

---
 rtl/stage5_pack_if.sv | 22 ++
 rtl/stage5_pack.sv | 98 +++++++++
 tb/tb_stage5_pack.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stage5_pack_if.sv
// Handshake bundle between the normalization stage, the FP16 packer and its consumer.
// The upstream/consumer side uses master; the packer uses slave.
interface stage5_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, sign, norm_sum, exp_final, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, sign, norm_sum, exp_final, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stage5_pack.sv
// Final FP16 packing stage: biases the exponent, handles zero/overflow/underflow and queues results in a 2-entry FIFO.
// Define FP16_SAT_EN to saturate overflow to max finite instead of infinity.
module stage5_pack (
  input  logic          clk,
  input  logic          rst,
  stage5_pack_if.slave  bus,
  input  logic          clr_cnt,
  output logic [7:0]    ovf_cnt,
  output logic [7:0]    unf_cnt
);

`ifdef FP16_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic signed [7:0] exp_ext;
  logic signed [7:0] be;
  logic              is_zero;
  logic              is_ovf;
  logic              is_unf;
  logic [15:0]       packed_word;

  logic [15:0]       mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // The 7-bit exponent is sign-extended so the +15 bias cannot wrap.
  assign exp_ext = {bus.exp_final[6], bus.exp_final};
  assign be      = exp_ext + 8'sd15;

  always_comb begin
    is_zero     = (bus.norm_sum == 11'd0);
    is_ovf      = !is_zero && (be >= 8'sd31);
    is_unf      = !is_zero && (be <= 8'sd0);
    packed_word = 16'h0000;
    if (is_zero)
      packed_word = 16'h0000;
    else if (is_ovf)
      packed_word = {bus.sign, OVF_MAG};
    else if (is_unf)
      packed_word = {bus.sign, 15'h0000};
    else
      packed_word = {bus.sign, be[4:0], bus.norm_sum[9:0]};
  end

  // Handshake status comes only from registered occupancy, never from out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 16'h0000;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= packed_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A clear in the same cycle as an event wins, so that event is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= 8'd0;
      unf_cnt <= 8'd0;
    end else if (clr_cnt) begin
      ovf_cnt <= 8'd0;
      unf_cnt <= 8'd0;
    end else begin
      if (push && is_ovf && (ovf_cnt != 8'hFF))
        ovf_cnt <= ovf_cnt + 8'd1;
      if (push && is_unf && (unf_cnt != 8'hFF))
        unf_cnt <= unf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stage5_pack.sv
// Directed bench for stage5_pack: packing cases, FIFO backpressure, counter saturation/clear and async reset.
module tb_stage5_pack;

`ifdef FP16_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic       clk;
  logic       rst;
  logic       clr_cnt;
  logic [7:0] ovf_cnt;
  logic [7:0] unf_cnt;
  int         tests_run;
  int         tests_failed;

  stage5_pack_if bus ();

  stage5_pack dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .clr_cnt (clr_cnt),
    .ovf_cnt (ovf_cnt),
    .unf_cnt (unf_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic s, input logic [10:0] n, input logic [6:0] e);
    bus.in_valid  = valid;
    bus.sign      = s;
    bus.norm_sum  = n;
    bus.exp_final = e;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    clr_cnt      = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);

    // Reset state
    #3;
    check_output("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
    check_output("reset_out_data", bus.out_data, 16'h0000);
    check_output("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
    check_output("reset_ovf_cnt", {8'd0, ovf_cnt}, 16'd0);
    check_output("reset_unf_cnt", {8'd0, unf_cnt}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;

    // 1.0: one-cycle latency
    apply_stimulus(1'b1, 1'b0, 11'h400, 7'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("one_valid", {15'd0, bus.out_valid}, 16'd1);
    check_output("one_data", bus.out_data, 16'h3C00);
    @(negedge clk);
    check_output("one_drained", {15'd0, bus.out_valid}, 16'd0);

    // Overflow
    apply_stimulus(1'b1, 1'b1, 11'h7FF, 7'd16);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("ovf_data", bus.out_data, {1'b1, OVF_MAG});
    check_output("ovf_cnt_1", {8'd0, ovf_cnt}, 16'd1);
    check_output("ovf_unf_still0", {8'd0, unf_cnt}, 16'd0);

    // Underflow at be == 0
    apply_stimulus(1'b1, 1'b0, 11'h500, 7'h71);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("unf_valid", {15'd0, bus.out_valid}, 16'd1);
    check_output("unf_data", bus.out_data, 16'h0000);
    check_output("unf_cnt_1", {8'd0, unf_cnt}, 16'd1);

    // Negative underflow keeps the sign
    apply_stimulus(1'b1, 1'b1, 11'h600, 7'h60);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("unf_neg_data", bus.out_data, 16'h8000);
    check_output("unf_cnt_2", {8'd0, unf_cnt}, 16'd2);

    // Zero magnitude with huge exponent: no counting
    apply_stimulus(1'b1, 1'b1, 11'h000, 7'd40);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("zero_valid", {15'd0, bus.out_valid}, 16'd1);
    check_output("zero_data", bus.out_data, 16'h0000);
    check_output("zero_ovf_cnt", {8'd0, ovf_cnt}, 16'd1);
    check_output("zero_unf_cnt", {8'd0, unf_cnt}, 16'd2);

    // Smallest normal exponent (be = 1) and largest (be = 30)
    apply_stimulus(1'b1, 1'b1, 11'h7FF, 7'h72);
    @(negedge clk);
    check_output("min_normal", bus.out_data, 16'h87FF);
    apply_stimulus(1'b1, 1'b0, 11'h555, 7'd15);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("max_normal", bus.out_data, 16'h7955);
    check_output("normal_no_count", {ovf_cnt, unf_cnt}, {8'd1, 8'd2});
    @(negedge clk);

    // Backpressure: three inputs with out_ready low
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 11'h400, 7'd0);
    @(negedge clk);
    check_output("bp_ready_1", {15'd0, bus.in_ready}, 16'd1);
    apply_stimulus(1'b1, 1'b1, 11'h400, 7'd1);
    @(negedge clk);
    check_output("bp_ready_full", {15'd0, bus.in_ready}, 16'd0);
    check_output("bp_head_a", bus.out_data, 16'h3C00);
    apply_stimulus(1'b1, 1'b0, 11'h600, 7'd2);
    @(negedge clk);
    check_output("bp_held_ready", {15'd0, bus.in_ready}, 16'd0);
    check_output("bp_stable_data", bus.out_data, 16'h3C00);
    check_output("bp_stable_valid", {15'd0, bus.out_valid}, 16'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("bp_drain_b", bus.out_data, 16'hC000);
    check_output("bp_ready_back", {15'd0, bus.in_ready}, 16'd1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("bp_drain_c", bus.out_data, 16'h4600);
    check_output("bp_drain_c_valid", {15'd0, bus.out_valid}, 16'd1);
    @(negedge clk);
    check_output("bp_empty", {15'd0, bus.out_valid}, 16'd0);

    // 300 overflows saturate the counter
    apply_stimulus(1'b1, 1'b0, 11'h400, 7'd20);
    for (int i = 0; i < 300; i++) @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("ovf_saturate", {8'd0, ovf_cnt}, 16'd255);
    check_output("ovf_sat_data", bus.out_data, {1'b0, OVF_MAG});
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check_output("clr_ovf", {8'd0, ovf_cnt}, 16'd0);
    check_output("clr_unf", {8'd0, unf_cnt}, 16'd0);

    // Event coinciding with clear is lost
    clr_cnt = 1'b1;
    apply_stimulus(1'b1, 1'b0, 11'h400, 7'd20);
    @(negedge clk);
    clr_cnt = 1'b0;
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("clr_event_lost", {8'd0, ovf_cnt}, 16'd0);
    @(negedge clk);

    // Async reset with two entries buffered
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 1'b1, 11'h7FF, 7'd16);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 11'h400, 7'd3);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("pre_rst_full", {15'd0, bus.in_ready}, 16'd0);
    check_output("pre_rst_ovf", {8'd0, ovf_cnt}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_async_valid", {15'd0, bus.out_valid}, 16'd0);
    check_output("rst_async_data", bus.out_data, 16'h0000);
    check_output("rst_async_ready", {15'd0, bus.in_ready}, 16'd1);
    check_output("rst_async_ovf", {8'd0, ovf_cnt}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("post_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0, 11'h480, 7'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 11'd0, 7'd0);
    check_output("post_rst_fresh", bus.out_data, 16'h3C80);
    @(negedge clk);
    check_output("post_rst_empty", {15'd0, bus.out_valid}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
